// File: rtl/weave_pkg.sv
// Shared constants and types for the weave adder arbiter slice.
// Port IDs, FSM state encoding and default widths.
package weave_pkg;

    localparam int W_DEFAULT     = 8;
    localparam int CNT_W_DEFAULT = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection, purely combinational.
// On contention the port that did not win last time is chosen.
module rr_arb2
    import weave_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = PORT1;
        end else begin
            grant = PORT0;
        end
    end

endmodule

// File: rtl/weave_adder_arbiter.sv
// One W-bit adder shared by two valid/ready requesters, round-robin arbitrated,
// feeding a single-entry result register with the winner's ID and grant counters.
module weave_adder_arbiter
    import weave_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic       last_grant;
    logic       grant;
    logic       grant_valid;
    logic       can_accept;
    logic       accept;
    logic [W:0] sum_full;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Readiness is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        can_accept = (state == ST_EMPTY) || res_ready;
        req0_ready = rst_n & can_accept & grant_valid & (grant == PORT0);
        req1_ready = rst_n & can_accept & grant_valid & (grant == PORT1);
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        if (grant == PORT1) begin
            sum_full = {1'b0, req1_a} + {1'b0, req1_b};
        end else begin
            sum_full = {1'b0, req0_a} + {1'b0, req0_b};
        end
        res_valid = (state == ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            last_grant <= PORT1;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            res_id     <= PORT0;
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
        end else if (accept) begin
            state      <= ST_FULL;
            last_grant <= grant;
            res_id     <= grant;
            {res_carry, res_sum} <= sum_full;
            if (grant == PORT0) begin
                if (gnt_cnt0 != CNT_MAX) gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
            end else begin
                if (gnt_cnt1 != CNT_MAX) gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
            end
        end else if ((state == ST_FULL) && res_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_weave_adder_arbiter.sv
// Directed self-checking bench for weave_adder_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from edges.
module tb_weave_adder_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_sum;
    logic       res_carry;
    logic       res_id;
    logic [7:0] gnt_cnt0;
    logic [7:0] gnt_cnt1;

    int errors = 0;
    int checks = 0;

    weave_adder_arbiter #(.W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                  input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                                  input logic rr);
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        res_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous assert between edges, synchronous-looking release just after an edge.
    task automatic pulse_reset();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("rst_res_valid", res_valid, 0);
        check_output("rst_res_sum",   res_sum,   0);
        check_output("rst_res_carry", res_carry, 0);
        check_output("rst_res_id",    res_id,    0);
        check_output("rst_cnt0",      gnt_cnt0,  0);
        check_output("rst_cnt1",      gnt_cnt1,  0);
        check_output("rst_req0_ready", req0_ready, 0);
        tick();
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        tick();

        // Single request from port 0
        apply_stimulus(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        check_output("t1_req0_ready", req0_ready, 1);
        check_output("t1_req1_ready", req1_ready, 0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        check_output("t1_res_valid", res_valid, 1);
        check_output("t1_res_sum",   res_sum,   8'h46);
        check_output("t1_res_carry", res_carry, 0);
        check_output("t1_res_id",    res_id,    0);
        check_output("t1_cnt0",      gnt_cnt0,  1);
        tick();
        check_output("t1_drain_valid", res_valid, 0);

        // Overflow from port 1
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'hF0, 8'h20, 1'b1);
        #1;
        check_output("t2_req1_ready", req1_ready, 1);
        check_output("t2_req0_ready", req0_ready, 0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        check_output("t2_res_sum",   res_sum,   8'h10);
        check_output("t2_res_carry", res_carry, 1);
        check_output("t2_res_id",    res_id,    1);
        check_output("t2_cnt1",      gnt_cnt1,  1);
        tick();

        // Fairness: both valid for four accepts
        pulse_reset();
        apply_stimulus(1'b1, 8'h01, 8'h01, 1'b1, 8'h10, 8'h10, 1'b1);
        tick();
        check_output("t3_id_0",  res_id,  0);
        check_output("t3_sum_0", res_sum, 8'h02);
        tick();
        check_output("t3_id_1",  res_id,  1);
        check_output("t3_sum_1", res_sum, 8'h20);
        tick();
        check_output("t3_id_2",  res_id,  0);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        check_output("t3_id_3",  res_id,  1);
        check_output("t3_valid", res_valid, 1);
        check_output("t3_cnt0",  gnt_cnt0, 2);
        check_output("t3_cnt1",  gnt_cnt1, 2);
        tick();
        check_output("t3_idle_valid", res_valid, 0);

        // Backpressure with a pending 8'h05 result
        apply_stimulus(1'b1, 8'h02, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("t4_pend_sum", res_sum, 8'h05);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'h40 + 8'(i), 8'h40, 1'b0, 8'h00, 8'h00, 1'b0);
            #1;
            check_output("t4_stall_ready", req0_ready, 0);
            tick();
            check_output("t4_stall_valid", res_valid, 1);
            check_output("t4_stall_sum",   res_sum,   8'h05);
            check_output("t4_stall_id",    res_id,    0);
        end
        apply_stimulus(1'b1, 8'h07, 8'h08, 1'b0, 8'h00, 8'h00, 1'b1);
        #1;
        check_output("t4_release_ready", req0_ready, 1);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        check_output("t4_release_valid", res_valid, 1);
        check_output("t4_release_sum",   res_sum,   8'h0F);
        tick();

        // Counter saturation
        pulse_reset();
        apply_stimulus(1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 300; i++) tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        check_output("t5_cnt0", gnt_cnt0, 255);
        check_output("t5_cnt1", gnt_cnt1, 0);
        tick();

        // Async reset while a result is held
        apply_stimulus(1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        check_output("t6_full_sum",   res_sum,   8'hAA);
        check_output("t6_full_valid", res_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t6_async_valid", res_valid, 0);
        check_output("t6_async_sum",   res_sum,   0);
        check_output("t6_async_cnt0",  gnt_cnt0,  0);
        tick();
        rst_n = 1'b1;
        apply_stimulus(1'b1, 8'h03, 8'h04, 1'b1, 8'h05, 8'h06, 1'b1);
        #1;
        check_output("t6_post_req0_ready", req0_ready, 1);
        check_output("t6_post_req1_ready", req1_ready, 0);
        tick();
        check_output("t6_post_id",  res_id,  0);
        check_output("t6_post_sum", res_sum, 8'h07);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
